// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO scheduler: sizes, FSM state codes and slot indices.
// The optional watermark logic in fifo_arb is enabled by defining FIFO_ARB_WMARK_EN.
package fifo_arb_pkg;

  localparam int DW       = 8;
  localparam int DEPTH    = 16;
  localparam int CW       = 5;
  localparam int AF_LEVEL = 12;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [1:0] SLOT_W0 = 2'd0;
  localparam logic [1:0] SLOT_W1 = 2'd1;
  localparam logic [1:0] SLOT_RD = 2'd2;

  // Next slot in the W0 -> W1 -> RD -> W0 rotation; an illegal code maps back to W0.
  function automatic logic [1:0] slot_next(input logic [1:0] s);
    return (s >= SLOT_RD) ? SLOT_W0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_arb3.sv
// Combinational three-way round-robin picker: the search starts at the slot
// after rr_ptr and the first eligible slot wins.
module rr_arb3
  import fifo_arb_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] rr_ptr,
  output logic [2:0] gnt,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  assign c0 = slot_next(rr_ptr);
  assign c1 = slot_next(c0);
  assign c2 = slot_next(c1);

  always_comb begin
    gnt = 3'b000;
    win = rr_ptr;
    any = 1'b0;
    if (elig[c0]) begin
      gnt[c0] = 1'b1;
      win     = c0;
      any     = 1'b1;
    end else if (elig[c1]) begin
      gnt[c1] = 1'b1;
      win     = c1;
      any     = 1'b1;
    end else if (elig[c2]) begin
      gnt[c2] = 1'b1;
      win     = c2;
      any     = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_arb.sv
// Scheduler for the shared 16x8 FIFO slot: two writers, one reader, occupancy flags, flush.
// Define FIFO_ARB_WMARK_EN for the registered almost_full flag and starvation-escape write throttling.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int DW       = fifo_arb_pkg::DW,
  parameter int DEPTH    = fifo_arb_pkg::DEPTH,
  parameter int CW       = fifo_arb_pkg::CW,
  parameter int AF_LEVEL = fifo_arb_pkg::AF_LEVEL
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  input  logic          rd_req,
  output logic          rd_ack,
  input  logic          flush,
  output logic          flush_busy,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wen_n,
  output logic          fifo_ren_n,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          state_dbg
);

  // Handshake: a requester raises req (or rd_req) and holds it, with stable din,
  // until it sees gnt (or rd_ack) in the same cycle; the transfer happens on the
  // rising ck that ends that cycle. A grant never waits for an earlier edge.

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  logic          is_full;
  logic          is_empty;
  logic          wr_ok0;
  logic          wr_ok1;
  logic [2:0]    elig;
  logic [2:0]    pick;
  logic [1:0]    win;
  logic          any;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

`ifdef FIFO_ARB_WMARK_EN
  logic       af_q, af_d;
  logic [2:0] starv0_q, starv0_d;
  logic [2:0] starv1_q, starv1_d;

  // A writer held off by the watermark becomes eligible again after 7 straight denials.
  assign wr_ok0 = !af_q || (starv0_q == 3'd7);
  assign wr_ok1 = !af_q || (starv1_q == 3'd7);
`else
  assign wr_ok0 = 1'b1;
  assign wr_ok1 = 1'b1;
`endif

  assign elig = {rd_req & ~is_empty,
                 req1 & ~is_full & wr_ok1,
                 req0 & ~is_full & wr_ok0};

  rr_arb3 u_rr_arb3 (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick),
    .win    (win),
    .any    (any)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rr_ptr_d   = rr_ptr_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rd_ack     = 1'b0;
    fifo_wen_n = 1'b1;
    fifo_ren_n = 1'b1;
    fifo_din   = '0;
    // Strobes stay idle throughout reset so the FIFO never sees a stray operation.
    if (!rst) begin
      case (state_q)
        ST_FLUSH: begin
          if (!is_empty) begin
            fifo_ren_n = 1'b0;
            count_d    = count_q - CW'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          if (flush) begin
            state_d = ST_FLUSH;
          end else if (any) begin
            rr_ptr_d = win;
            if (pick[SLOT_W0]) begin
              gnt0       = 1'b1;
              fifo_wen_n = 1'b0;
              fifo_din   = din0;
              count_d    = count_q + CW'(1);
            end else if (pick[SLOT_W1]) begin
              gnt1       = 1'b1;
              fifo_wen_n = 1'b0;
              fifo_din   = din1;
              count_d    = count_q + CW'(1);
            end else begin
              rd_ack     = 1'b1;
              fifo_ren_n = 1'b0;
              count_d    = count_q - CW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      count_q  <= '0;
      rr_ptr_q <= SLOT_RD;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FIFO_ARB_WMARK_EN
  always_comb begin
    af_d     = af_q;
    starv0_d = 3'd0;
    starv1_d = 3'd0;
    if (count_d >= CW'(AF_LEVEL)) begin
      af_d = 1'b1;
    end else if (count_d <= CW'(AF_LEVEL - 4)) begin
      af_d = 1'b0;
    end
    if (state_q == ST_RUN && req0 && !gnt0) begin
      starv0_d = (starv0_q == 3'd7) ? 3'd7 : starv0_q + 3'd1;
    end
    if (state_q == ST_RUN && req1 && !gnt1) begin
      starv1_d = (starv1_q == 3'd7) ? 3'd7 : starv1_q + 3'd1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      af_q     <= 1'b0;
      starv0_q <= 3'd0;
      starv1_q <= 3'd0;
    end else begin
      af_q     <= af_d;
      starv0_q <= starv0_d;
      starv1_q <= starv1_d;
    end
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign flush_busy = (state_q == ST_FLUSH);
  assign state_dbg  = state_q[0];

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: directed scenarios plus random traffic, checked against a
// queue-based model of the FIFO contents, round-robin order and flush draining.
module tb_fifo_arb;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       gnt0, gnt1, rd_ack, flush_busy, fifo_wen_n, fifo_ren_n;
  logic       empty, full, almost_full, state_dbg;
  logic [7:0] fifo_din;
  logic [4:0] count;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Scoreboard state: FIFO contents, last winner (0=W0,1=W1,2=RD), draining flag.
  logic [7:0] exp_q[$];
  int         m_ptr = 2;
  bit         m_flush = 1'b0;

  // Simple FIFO core driven by the DUT strobes, as in the real system.
  logic [7:0] fmem [16];
  logic [3:0] wp, rp;
  logic [7:0] fdout;
  assign fdout = fmem[rp];

  always #5 ck = ~ck;

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      wp <= 4'd0;
      rp <= 4'd0;
    end else begin
      if (!fifo_wen_n) begin
        fmem[wp] <= fifo_din;
        wp       <= wp + 4'd1;
      end
      if (!fifo_ren_n) rp <= rp + 4'd1;
    end
  end

  fifo_arb dut (
    .ck          (ck),
    .rst         (rst),
    .req0        (req0),
    .din0        (din0),
    .gnt0        (gnt0),
    .req1        (req1),
    .din1        (din1),
    .gnt1        (gnt1),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .flush       (flush),
    .flush_busy  (flush_busy),
    .fifo_din    (fifo_din),
    .fifo_wen_n  (fifo_wen_n),
    .fifo_ren_n  (fifo_ren_n),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
    check({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
    check({tag, "_wen_n"}, 32'(fifo_wen_n), 32'd1);
    check({tag, "_ren_n"}, 32'(fifo_ren_n), 32'd1);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_busy"}, 32'(flush_busy), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr   = 2;
    m_flush = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge ck);
    req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1; flush = 1'b0;
    rst  = 1'b1;
    #1;
    check_idle_outputs("reset");
    model_reset();
    @(negedge ck);
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r0, input logic [7:0] d0, input logic r1,
                      input logic [7:0] d1, input logic rr, input logic fl);
    int         cnt;
    int         win;
    int         s;
    bit         el [3];
    bit         next_flush;
    logic       e_g0, e_g1, e_ack, e_wen, e_ren;
    logic [7:0] e_din;
    @(negedge ck);
    req0 = r0; din0 = d0; req1 = r1; din1 = d1; rd_req = rr; flush = fl;
    #1;
    cnt = exp_q.size();
    e_g0 = 0; e_g1 = 0; e_ack = 0; e_wen = 1; e_ren = 1; e_din = 8'h00;
    win = -1;
    next_flush = m_flush;
    if (m_flush) begin
      if (cnt > 0) e_ren = 0;
      else next_flush = 0;
    end else if (fl) begin
      next_flush = 1;
    end else begin
      el[0] = r0 && cnt < 16;
      el[1] = r1 && cnt < 16;
      el[2] = rr && cnt > 0;
      for (int k = 1; k <= 3; k++) begin
        s = (m_ptr + k) % 3;
        if (win < 0 && el[s]) win = s;
      end
      if (win == 0) begin e_g0 = 1; e_wen = 0; e_din = d0; end
      if (win == 1) begin e_g1 = 1; e_wen = 0; e_din = d1; end
      if (win == 2) begin e_ack = 1; e_ren = 0; end
    end
    check("gnt0", 32'(gnt0), 32'(e_g0));
    check("gnt1", 32'(gnt1), 32'(e_g1));
    check("rd_ack", 32'(rd_ack), 32'(e_ack));
    check("wen_n", 32'(fifo_wen_n), 32'(e_wen));
    check("ren_n", 32'(fifo_ren_n), 32'(e_ren));
    check("fifo_din", 32'(fifo_din), 32'(e_din));
    check("count", 32'(count), 32'(cnt));
    check("empty", 32'(empty), 32'(cnt == 0));
    check("full", 32'(full), 32'(cnt == 16));
    check("flush_busy", 32'(flush_busy), 32'(m_flush));
    check("state_dbg", 32'(state_dbg), 32'(m_flush));
    check("almost_full", 32'(almost_full), 32'd0);
    check("one_op", 32'(fifo_wen_n | fifo_ren_n), 32'd1);
    if (win == 2) check("rd_data", 32'(fdout), 32'(exp_q[0]));
    if (win == 0 || win == 1) begin
      exp_q.push_back(e_din);
      m_ptr = win;
    end
    if (win == 2) begin
      void'(exp_q.pop_front());
      m_ptr = 2;
    end
    if (m_flush && cnt > 0) void'(exp_q.pop_front());
    m_flush = next_flush;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    apply_reset();

    // Fairness between writers, then read back in order.
    repeat (4) step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, denied writes, read frees one slot, W0 refills.
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Three-way contention from empty.
    apply_reset();
    repeat (6) step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b0);

    // Flush with five entries while W0 keeps requesting.
    apply_reset();
    repeat (5) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (8) step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush from empty, and a flush pulse repeated during the drain.
    apply_reset();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
    repeat (3) step(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(4);

    // Asynchronous reset in the middle of a drain.
    apply_reset();
    repeat (5) step(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    model_reset();
    @(negedge ck);
    rst = 1'b0;
    repeat (3) step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with alternating write-heavy and read-heavy phases.
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      int wbias;
      wbias = ((i / 100) % 2 == 0) ? 80 : 25;
      step(1'($urandom_range(0, 99) < wbias), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < wbias), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 100 - wbias),
           1'($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
